// File: rtl/riscv_mem_pkg.sv
// Shared types and address-map defaults for the data-memory path.
// Used by the load/store unit and the data-memory controller.
`ifndef DATA_MEM_BEGIN
`define DATA_MEM_BEGIN 32'h1001_0000
`endif
`ifndef DATA_MEM_END
`define DATA_MEM_END 32'h1001_ffff
`endif

package riscv_mem_pkg;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd4,
        LHU = 3'd5
    } data_format_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE0,
        S_WAIT0,
        S_ISSUE1,
        S_WAIT1,
        S_RESP
    } dmc_state_t;

    localparam logic [31:0] DMC_DATA_BEGIN = `DATA_MEM_BEGIN;
    localparam logic [31:0] DMC_DATA_END   = `DATA_MEM_END;

    // Unshifted byte-lane mask for an access size (0 B, 1 H, 2 W).
    function automatic logic [3:0] lane_mask(input logic [1:0] size);
        unique case (size)
            2'd0:    lane_mask = 4'b0001;
            2'd1:    lane_mask = 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmc_lane_align.sv
// Byte-lane steering for the data-memory controller.
// Positions store data/enables over two words and extracts load results.
module dmc_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] q0_i,
    input  logic [31:0] q1_i,
    output logic [3:0]  byteena0_o,
    output logic [3:0]  byteena1_o,
    output logic [31:0] data0_o,
    output logic [31:0] data1_o,
    output logic [31:0] rdata_o
);

    logic [4:0]  sh;
    logic [7:0]  be_wide;
    logic [63:0] wd_wide;
    logic [63:0] rd_cat;
    logic [31:0] rd_raw;

    assign sh      = {off_i, 3'b000};
    assign be_wide = {4'b0000, lane_mask(size_i)} << off_i;
    assign wd_wide = {32'h0, wdata_i} << sh;
    assign rd_cat  = {q1_i, q0_i};
    assign rd_raw  = 32'(rd_cat >> sh);

    assign byteena0_o = be_wide[3:0];
    assign byteena1_o = be_wide[7:4];
    assign data0_o    = wd_wide[31:0];
    assign data1_o    = wd_wide[63:32];

    // Truncate the realigned word to the access size and extend it.
    always_comb begin
        rdata_o = rd_raw;
        unique case (size_i)
            2'd0:    rdata_o = {{24{~uns_i & rd_raw[7]}}, rd_raw[7:0]};
            2'd1:    rdata_o = {{16{~uns_i & rd_raw[15]}}, rd_raw[15:0]};
            default: rdata_o = rd_raw;
        endcase
    end

endmodule

// File: rtl/data_memory_controller.sv
// Multi-cycle data-memory controller between the LSU and a synchronous RAM.
// Splits misaligned accesses, extends loads, reports range/format faults.
module data_memory_controller
    import riscv_mem_pkg::*;
#(
    parameter int unsigned MEM_ADDR_BITS  = 15,
    parameter logic [31:0] DATA_BEGIN     = DMC_DATA_BEGIN,
    parameter logic [31:0] DATA_END       = DMC_DATA_END,
    parameter int unsigned MEM_LATENCY    = 1,
    parameter bit          SPLIT_MISALIGN = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [2:0]               req_format,
    input  logic [31:0]              req_address,
    input  logic [31:0]              req_wdata,
    output logic                     resp_valid,
    output logic [31:0]              resp_rdata,
    output logic                     resp_fault,
    output logic [MEM_ADDR_BITS-1:0] mem_address,
    output logic [3:0]               mem_byteena,
    output logic                     mem_wren,
    output logic [31:0]              mem_data,
    input  logic [31:0]              mem_q
);

    localparam int unsigned CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

    dmc_state_t              state_q;
    logic                    write_q;
    logic [1:0]              size_q;
    logic                    uns_q;
    logic [1:0]              off_q;
    logic [31:0]             wdata_q;
    logic                    split_q;
    logic [MEM_ADDR_BITS-1:0] waddr_q;
    logic [CW-1:0]           cnt_q;
    logic [31:0]             q0_q;
    logic [31:0]             q1_q;

    logic                    req_ready_q;
    logic                    resp_valid_q;
    logic                    resp_fault_q;
    logic [31:0]             resp_rdata_q;
    logic [MEM_ADDR_BITS-1:0] mem_address_q;
    logic [3:0]              mem_byteena_q;
    logic                    mem_wren_q;
    logic [31:0]             mem_data_q;

    logic [MEM_ADDR_BITS-1:0] waddr1_d;

    logic [1:0]  req_off;
    logic [1:0]  req_size;
    logic [3:0]  req_nbytes;
    logic [32:0] req_first;
    logic [32:0] req_last;
    logic        req_range;
    logic        req_split;
    logic        req_fault;

    logic        idle;
    logic [1:0]  al_size;
    logic [1:0]  al_off;
    logic [31:0] al_wdata;
    logic [31:0] al_q0;
    logic [31:0] al_q1;
    logic [3:0]  al_be0;
    logic [3:0]  al_be1;
    logic [31:0] al_data0;
    logic [31:0] al_data1;
    logic [31:0] al_rdata;

    assign req_off    = req_address[1:0];
    assign req_size   = req_format[1:0];
    assign req_nbytes = 4'd1 << req_size;
    assign req_first  = {1'b0, req_address};
    assign req_last   = req_first + {29'd0, req_nbytes} - 33'd1;
    assign req_range  = (req_first >= {1'b0, DATA_BEGIN})
                     && (req_last <= {1'b0, DATA_END});
    assign req_split  = ({2'b00, req_off} + req_nbytes) > 4'd4;
    assign req_fault  = !req_range
                     || (req_size == 2'b11)
                     || (req_split && !SPLIT_MISALIGN);

    assign waddr1_d = waddr_q + 1'b1;

    // In IDLE the aligner steers the incoming request so ISSUE0 can be
    // registered at acceptance; afterwards it works on the held request.
    assign idle     = (state_q == S_IDLE);
    assign al_size  = idle ? req_size : size_q;
    assign al_off   = idle ? req_off : off_q;
    assign al_wdata = idle ? req_wdata : wdata_q;
    assign al_q0    = (state_q == S_WAIT0) ? mem_q : q0_q;
    assign al_q1    = (state_q == S_WAIT1) ? mem_q : q1_q;

    dmc_lane_align u_align (
        .size_i     (al_size),
        .off_i      (al_off),
        .uns_i      (uns_q),
        .wdata_i    (al_wdata),
        .q0_i       (al_q0),
        .q1_i       (al_q1),
        .byteena0_o (al_be0),
        .byteena1_o (al_be1),
        .data0_o    (al_data0),
        .data1_o    (al_data1),
        .rdata_o    (al_rdata)
    );

    // Access sequencer with registered RAM strobes and response outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            write_q       <= 1'b0;
            size_q        <= 2'd0;
            uns_q         <= 1'b0;
            off_q         <= 2'd0;
            wdata_q       <= 32'h0;
            split_q       <= 1'b0;
            waddr_q       <= '0;
            cnt_q         <= '0;
            q0_q          <= 32'h0;
            q1_q          <= 32'h0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_fault_q  <= 1'b0;
            resp_rdata_q  <= 32'h0;
            mem_address_q <= '0;
            mem_byteena_q <= 4'b0000;
            mem_wren_q    <= 1'b0;
            mem_data_q    <= 32'h0;
        end else begin
            mem_wren_q    <= 1'b0;
            mem_byteena_q <= 4'b0000;
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        write_q     <= req_write;
                        size_q      <= req_size;
                        uns_q       <= req_format[2];
                        off_q       <= req_off;
                        wdata_q     <= req_wdata;
                        split_q     <= req_split;
                        waddr_q     <= req_address[MEM_ADDR_BITS+1:2];
                        req_ready_q <= 1'b0;
                        if (req_fault) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= 1'b1;
                        end else begin
                            state_q       <= S_ISSUE0;
                            mem_address_q <= req_address[MEM_ADDR_BITS+1:2];
                            mem_byteena_q <= al_be0;
                            mem_data_q    <= al_data0;
                            mem_wren_q    <= req_write;
                        end
                    end
                end
                S_ISSUE0: begin
                    cnt_q <= CNT_INIT;
                    if (!write_q) begin
                        state_q <= S_WAIT0;
                    end else if (split_q) begin
                        state_q       <= S_ISSUE1;
                        mem_address_q <= waddr1_d;
                        mem_byteena_q <= al_be1;
                        mem_data_q    <= al_data1;
                        mem_wren_q    <= 1'b1;
                    end else begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                    end
                end
                S_WAIT0: begin
                    if (cnt_q == '0) begin
                        q0_q <= mem_q;
                        if (split_q) begin
                            state_q       <= S_ISSUE1;
                            mem_address_q <= waddr1_d;
                            mem_byteena_q <= al_be1;
                            mem_data_q    <= al_data1;
                        end else begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= al_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_ISSUE1: begin
                    cnt_q <= CNT_INIT;
                    if (write_q) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                    end else begin
                        state_q <= S_WAIT1;
                    end
                end
                S_WAIT1: begin
                    if (cnt_q == '0) begin
                        q1_q         <= mem_q;
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= al_rdata;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_RESP: begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_fault_q <= 1'b0;
                    resp_rdata_q <= 32'h0;
                    req_ready_q  <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_fault  = resp_fault_q;
    assign resp_rdata  = resp_rdata_q;
    assign mem_address = mem_address_q;
    assign mem_byteena = mem_byteena_q;
    assign mem_wren    = mem_wren_q;
    assign mem_data    = mem_data_q;

endmodule

// File: tb/tb_data_memory_controller.sv
// Directed bench for data_memory_controller: three instances
// (latency 1, latency 3, latency 1 without splitting) with RAM models.
module tb_data_memory_controller;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    logic        req_valid   [3];
    logic        req_ready   [3];
    logic        req_write   [3];
    logic [2:0]  req_format  [3];
    logic [31:0] req_address [3];
    logic [31:0] req_wdata   [3];
    logic        resp_valid  [3];
    logic [31:0] resp_rdata  [3];
    logic        resp_fault  [3];
    logic [14:0] mem_address [3];
    logic [3:0]  mem_byteena [3];
    logic        mem_wren    [3];
    logic [31:0] mem_data    [3];
    logic [31:0] mem_q       [3];
    int          acc_w       [3];
    logic [50:0] wlog0_w     [3];
    logic [50:0] wlog1_w     [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 1) ? 3 : 1;
        localparam int SPL = (g == 2) ? 0 : 1;

        logic [31:0] ram  [32768];
        logic [31:0] pipe [3];
        int          acc;
        logic [50:0] lg0;
        logic [50:0] lg1;

        data_memory_controller #(
            .MEM_ADDR_BITS  (15),
            .MEM_LATENCY    (LAT),
            .SPLIT_MISALIGN (SPL != 0)
        ) u_dut (
            .clock       (clock),
            .reset_n     (reset_n),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .req_write   (req_write[g]),
            .req_format  (req_format[g]),
            .req_address (req_address[g]),
            .req_wdata   (req_wdata[g]),
            .resp_valid  (resp_valid[g]),
            .resp_rdata  (resp_rdata[g]),
            .resp_fault  (resp_fault[g]),
            .mem_address (mem_address[g]),
            .mem_byteena (mem_byteena[g]),
            .mem_wren    (mem_wren[g]),
            .mem_data    (mem_data[g]),
            .mem_q       (mem_q[g])
        );

        initial begin
            acc = 0;
            lg0 = '0;
            lg1 = '0;
            ram[15'h4000] = 32'h8012_3456;
            ram[15'h4001] = 32'h8899_AABB;
            ram[15'h4002] = 32'h0000_0000;
            ram[15'h7fff] = 32'h1122_3344;
        end

        // Synchronous RAM: lane writes, reads delayed by LAT cycles.
        always @(posedge clock) begin
            if (mem_byteena[g] != 4'b0000 || mem_wren[g]) acc = acc + 1;
            if (mem_wren[g]) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteena[g][b])
                        ram[mem_address[g]][8*b +: 8] = mem_data[g][8*b +: 8];
                lg0 = lg1;
                lg1 = {mem_address[g], mem_byteena[g], mem_data[g]};
            end
            pipe[0] <= (mem_byteena[g] != 4'b0000 && !mem_wren[g])
                       ? ram[mem_address[g]] : 32'h5A5A_5A5A;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end

        assign mem_q[g]   = pipe[LAT-1];
        assign acc_w[g]   = acc;
        assign wlog0_w[g] = lg0;
        assign wlog1_w[g] = lg1;
    end

    typedef struct {
        bit          wr;
        logic [2:0]  fmt;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        bit          flt;
        int          la;
        int          lb;
        int          acc;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input int d, input bit wr, input logic [2:0] fmt,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_write[d]   = wr;
        req_format[d]  = fmt;
        req_address[d] = addr;
        req_wdata[d]   = wd;
    endtask

    task automatic run_req(input int d, input bit wr, input logic [2:0] fmt,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output bit flt,
                           output int lat, output bit hs_bad);
        int n;
        @(negedge clock);
        drive(d, wr, fmt, addr, wd);
        req_valid[d] = 1'b1;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        req_valid[d] = 1'b0;
        lat = 0;
        rd = 32'h0;
        flt = 1'b0;
        hs_bad = (n >= 50);
        for (int k = 1; k <= 50 && lat == 0; k++) begin
            if (req_ready[d]) hs_bad = 1'b1;
            if (resp_valid[d]) begin
                lat = k;
                rd = resp_rdata[d];
                flt = resp_fault[d];
            end else begin
                @(negedge clock);
            end
        end
        @(negedge clock);
        if (resp_valid[d] || !req_ready[d]) hs_bad = 1'b1;
    endtask

    task automatic apply(input int d, input int idx, input vec_t v);
        logic [31:0] rd;
        bit flt;
        int lat;
        bit hb;
        int a0;
        int lmem;
        lmem = (d == 1) ? 3 : 1;
        a0 = acc_w[d];
        run_req(d, v.wr, v.fmt, v.addr, v.wd, rd, flt, lat, hb);
        chk($sformatf("d%0d_v%0d_rdata", d, idx), 64'(rd), 64'(v.rd));
        chk($sformatf("d%0d_v%0d_fault", d, idx), 64'(flt), 64'(v.flt));
        chk($sformatf("d%0d_v%0d_latency", d, idx), 64'(lat),
            64'(v.la + v.lb * lmem));
        chk($sformatf("d%0d_v%0d_handshake", d, idx), 64'(hb), 64'(0));
        chk($sformatf("d%0d_v%0d_ram_access", d, idx), 64'(acc_w[d] - a0),
            64'(v.acc));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        vec_t vt [16];
        vec_t vn [4];
        vec_t vr;
        logic [31:0] rd;
        bit flt;
        int lat;
        bit hb;
        int nresp;
        int acc_n;
        int rsp_n;
        int bad;

        vt[0]  = '{1'b0, 3'd2, 32'h1001_0004, 32'h0, 32'h8899_AABB, 1'b0, 2, 1, 1};
        vt[1]  = '{1'b0, 3'd0, 32'h1001_0003, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 1, 1};
        vt[2]  = '{1'b0, 3'd4, 32'h1001_0003, 32'h0, 32'h0000_0080, 1'b0, 2, 1, 1};
        vt[3]  = '{1'b0, 3'd1, 32'h1001_0002, 32'h0, 32'hFFFF_8012, 1'b0, 2, 1, 1};
        vt[4]  = '{1'b0, 3'd5, 32'h1001_0003, 32'h0, 32'h0000_BB80, 1'b0, 3, 2, 2};
        vt[5]  = '{1'b1, 3'd2, 32'h1001_0002, 32'hDEAD_BEEF, 32'h0, 1'b0, 3, 0, 2};
        vt[6]  = '{1'b0, 3'd2, 32'h1001_0002, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 2, 2};
        vt[7]  = '{1'b1, 3'd0, 32'h1001_0005, 32'h0000_00A5, 32'h0, 1'b0, 2, 0, 1};
        vt[8]  = '{1'b0, 3'd2, 32'h1001_0004, 32'h0, 32'h8899_A5AD, 1'b0, 2, 1, 1};
        vt[9]  = '{1'b0, 3'd2, 32'h1000_FFFC, 32'h0, 32'h0, 1'b1, 1, 0, 0};
        vt[10] = '{1'b0, 3'd3, 32'h1001_0000, 32'h0, 32'h0, 1'b1, 1, 0, 0};
        vt[11] = '{1'b0, 3'd2, 32'h1001_FFFC, 32'h0, 32'h1122_3344, 1'b0, 2, 1, 1};
        vt[12] = '{1'b0, 3'd2, 32'h1001_FFFE, 32'h0, 32'h0, 1'b1, 1, 0, 0};
        vt[13] = '{1'b0, 3'd1, 32'h1001_FFFE, 32'h0, 32'h0000_1122, 1'b0, 2, 1, 1};
        vt[14] = '{1'b1, 3'd1, 32'h1001_0007, 32'h0000_1234, 32'h0, 1'b0, 3, 0, 2};
        vt[15] = '{1'b0, 3'd5, 32'h1001_0007, 32'h0, 32'h0000_1234, 1'b0, 3, 2, 2};

        vn[0] = '{1'b0, 3'd1, 32'h1001_0003, 32'h0, 32'h0, 1'b1, 1, 0, 0};
        vn[1] = '{1'b0, 3'd2, 32'h1001_0004, 32'h0, 32'h8899_AABB, 1'b0, 2, 1, 1};
        vn[2] = '{1'b0, 3'd1, 32'h1001_0002, 32'h0, 32'hFFFF_8012, 1'b0, 2, 1, 1};
        vn[3] = '{1'b1, 3'd2, 32'h1001_0001, 32'h1234_5678, 32'h0, 1'b1, 1, 0, 0};

        reset_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 1'b0;
            drive(d, 1'b0, 3'd0, 32'h0, 32'h0);
        end
        repeat (3) @(negedge clock);

        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d_rst_ctl", d),
                64'({req_ready[d], resp_valid[d], resp_fault[d],
                     mem_wren[d], mem_byteena[d]}), 64'h80);
            chk($sformatf("d%0d_rst_addr", d), 64'(mem_address[d]), 64'h0);
            chk($sformatf("d%0d_rst_data", d),
                64'({mem_data[d], resp_rdata[d]}), 64'h0);
        end

        reset_n = 1'b1;
        @(negedge clock);

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++)
                apply(d, i, vt[i]);

        for (int i = 0; i < 4; i++)
            apply(2, i, vn[i]);

        // Split store lane placement on the latency-1 instance.
        run_req(0, 1'b1, 3'd2, 32'h1001_0002, 32'hDEAD_BEEF, rd, flt, lat, hb);
        chk("sw_split_latency", 64'(lat), 64'(3));
        chk("sw_split_word0", 64'(wlog0_w[0]),
            64'({15'h4000, 4'b1100, 32'hBEEF_0000}));
        chk("sw_split_word1", 64'(wlog1_w[0]),
            64'({15'h4001, 4'b0011, 32'h0000_DEAD}));

        // Reset during WAIT0 of a split load on the latency-3 instance.
        @(negedge clock);
        drive(1, 1'b0, 3'd5, 32'h1001_0003, 32'h0);
        req_valid[1] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid[1] = 1'b0;
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_ctl",
            64'({req_ready[1], resp_valid[1], resp_fault[1],
                 mem_wren[1], mem_byteena[1]}), 64'h80);
        chk("mid_rst_addr", 64'(mem_address[1]), 64'h0);
        chk("mid_rst_data", 64'({mem_data[1], resp_rdata[1]}), 64'h0);
        nresp = 0;
        repeat (4) begin
            @(negedge clock);
            if (resp_valid[1]) nresp++;
        end
        reset_n = 1'b1;
        repeat (8) begin
            @(negedge clock);
            if (resp_valid[1]) nresp++;
        end
        chk("mid_rst_no_resp", 64'(nresp), 64'(0));
        vr = '{1'b0, 3'd5, 32'h1001_0003, 32'h0, 32'h0000_ADBE, 1'b0, 3, 2, 2};
        apply(1, 99, vr);

        // Back-to-back loads with req_valid held high.
        acc_n = 0;
        rsp_n = 0;
        bad = 0;
        @(negedge clock);
        drive(0, 1'b0, 3'd2, 32'h1001_0004, 32'h0);
        req_valid[0] = 1'b1;
        for (int k = 0; k < 24; k++) begin
            if (k > 0) @(negedge clock);
            if (resp_valid[0]) begin
                rsp_n++;
                if (resp_rdata[0] !== 32'h3499_DEAD || resp_fault[0]) bad++;
                if (req_ready[0]) bad++;
            end
            if (req_ready[0]) acc_n++;
        end
        @(negedge clock);
        req_valid[0] = 1'b0;
        repeat (12) begin
            if (resp_valid[0]) begin
                rsp_n++;
                if (resp_rdata[0] !== 32'h3499_DEAD || resp_fault[0]) bad++;
                if (req_ready[0]) bad++;
            end
            @(negedge clock);
        end
        chk("b2b_accepts", 64'(acc_n), 64'(6));
        chk("b2b_responses", 64'(rsp_n), 64'(6));
        chk("b2b_resp_ok", 64'(bad), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
